// File: rtl/dmem_ctrl.sv
// dmem_ctrl: multi-cycle data memory with valid/ready requests, wait states and b/h/w access
module dmem_ctrl #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_n;
    logic [3:0]  cnt;
    logic        we_q;
    logic [2:0]  size_q;
    logic [31:0] addr_q, wdata_q;
    logic [31:0] mem [DEPTH];
    logic        accept, enter;
    logic        a_we;
    logic [2:0]  a_size;
    logic [31:0] a_addr, a_wdata;
    logic [AW-1:0] idx;
    logic [31:0] word, rdata_n, wval;
    logic [7:0]  bsel;
    logic [15:0] hsel;
    logic [3:0]  wmask;
    logic        err;

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state == IDLE ? (accept ? (LATENCY == 0 ? RESP : WAIT) : IDLE) :
                  state == WAIT ? (cnt == 4'd1 ? RESP : WAIT) : IDLE;
    end

    always_comb begin
        req_ready = reset && state == IDLE;
        busy      = state != IDLE;
        rsp_valid = state == RESP;
    end

    // With zero wait states the access happens on the accept edge, so use the live request
    always_comb begin
        accept  = req_valid && req_ready;
        enter   = state_n == RESP && state != RESP;
        a_we    = state == IDLE ? req_we    : we_q;
        a_size  = state == IDLE ? req_size  : size_q;
        a_addr  = state == IDLE ? req_addr  : addr_q;
        a_wdata = state == IDLE ? req_wdata : wdata_q;
        idx     = a_addr[AW+1:2];
        word    = mem[idx];
        err     = a_size inside {3'b011, 3'b110, 3'b111} || (a_we && a_size[2]) ||
                  (a_size[1:0] == 2'b01 && a_addr[0]) ||
                  (a_size[1:0] == 2'b10 && a_addr[1:0] != 2'b00) ||
                  {2'b00, a_addr[31:2]} >= 32'(DEPTH);
        bsel    = word[8*a_addr[1:0] +: 8];
        hsel    = a_addr[1] ? word[31:16] : word[15:0];
        rdata_n = (err || a_we) ? 32'd0 :
                  a_size[1:0] == 2'b00 ? {{24{!a_size[2] && bsel[7]}}, bsel} :
                  a_size[1:0] == 2'b01 ? {{16{!a_size[2] && hsel[15]}}, hsel} : word;
        wmask   = a_size[1:0] == 2'b00 ? 4'b0001 << a_addr[1:0] :
                  a_size[1:0] == 2'b01 ? (a_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wval    = a_size[1:0] == 2'b00 ? {4{a_wdata[7:0]}} :
                  a_size[1:0] == 2'b01 ? {2{a_wdata[15:0]}} : a_wdata;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt       <= 4'd0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                we_q    <= req_we;
                size_q  <= req_size;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                cnt     <= 4'(LATENCY);
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (enter) begin
                rsp_rdata <= rdata_n;
                rsp_err   <= err;
            end
        end
    end

    // Memory is never cleared; a reset on the commit edge drops the pending store
    always_ff @(posedge clk) begin
        if (reset && enter && a_we && !err)
            for (int i = 0; i < 4; i++)
                if (wmask[i]) mem[idx][8*i +: 8] <= wval[8*i +: 8];
    end
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed vector table plus reset and back-to-back sequences for dmem_ctrl
module tb_dmem_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic        req_valid, req_we;
    logic [2:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        ready0, rv0, err0, busy0, ready1, rv1, err1, busy1;
    logic [31:0] rdata0, rdata1;
    logic        ready, rv, err, busy;
    logic [31:0] rdata;
    int          total = 0;
    int          passed = 0;

    always #5 clk = ~clk;

    dmem_ctrl #(.DEPTH(64), .LATENCY(2)) dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid && !sel), .req_ready(ready0),
        .req_we(req_we), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv0), .rsp_rdata(rdata0), .rsp_err(err0), .busy(busy0));

    dmem_ctrl #(.DEPTH(64), .LATENCY(0)) dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid && sel), .req_ready(ready1),
        .req_we(req_we), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv1), .rsp_rdata(rdata1), .rsp_err(err1), .busy(busy1));

    assign ready = sel ? ready1 : ready0;
    assign rv    = sel ? rv1    : rv0;
    assign err   = sel ? err1   : err0;
    assign busy  = sel ? busy1  : busy0;
    assign rdata = sel ? rdata1 : rdata0;

    typedef struct {
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    vec_t tbl[24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    task automatic txn(input int lat, input vec_t v, input string name);
        int cyc;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = v.we;
        req_size  = v.size;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        #1 chk({name, " ready"}, 32'(ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        cyc = 1;
        while (!rv && cyc < 40) begin
            @(posedge clk);
            #1 cyc++;
        end
        chk({name, " latency"}, 32'(cyc), 32'(lat + 1));
        chk({name, " rdata"}, rdata, v.rdata);
        chk({name, " err"}, 32'(err), 32'(v.err));
        @(posedge clk);
        #1;
        chk({name, " pulse"}, 32'(rv), 32'd0);
        chk({name, " ready after"}, 32'(ready), 32'd1);
        chk({name, " hold"}, rdata, v.rdata);
    endtask

    initial begin
        int acc, rsp, bad, seen;
        vec_t v;
        tbl[0]  = '{1'b1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
        tbl[1]  = '{1'b0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b0, 3'b000, 32'h13,  32'h0,        32'hFFFFFFDE, 1'b0};
        tbl[3]  = '{1'b0, 3'b100, 32'h13,  32'h0,        32'h000000DE, 1'b0};
        tbl[4]  = '{1'b0, 3'b001, 32'h10,  32'h0,        32'hFFFFBEEF, 1'b0};
        tbl[5]  = '{1'b0, 3'b101, 32'h12,  32'h0,        32'h0000DEAD, 1'b0};
        tbl[6]  = '{1'b1, 3'b000, 32'h11,  32'h55,       32'h0,        1'b0};
        tbl[7]  = '{1'b0, 3'b010, 32'h10,  32'h0,        32'hDEAD55EF, 1'b0};
        tbl[8]  = '{1'b1, 3'b001, 32'h12,  32'h1234,     32'h0,        1'b0};
        tbl[9]  = '{1'b0, 3'b010, 32'h10,  32'h0,        32'h123455EF, 1'b0};
        tbl[10] = '{1'b0, 3'b010, 32'h12,  32'h0,        32'h0,        1'b1};
        tbl[11] = '{1'b0, 3'b001, 32'h11,  32'h0,        32'h0,        1'b1};
        tbl[12] = '{1'b0, 3'b010, 32'h100, 32'h0,        32'h0,        1'b1};
        tbl[13] = '{1'b0, 3'b011, 32'h10,  32'h0,        32'h0,        1'b1};
        tbl[14] = '{1'b1, 3'b010, 32'h12,  32'hFFFFFFFF, 32'h0,        1'b1};
        tbl[15] = '{1'b0, 3'b010, 32'h10,  32'h0,        32'h123455EF, 1'b0};
        tbl[16] = '{1'b1, 3'b100, 32'h10,  32'hFFFFFFFF, 32'h0,        1'b1};
        tbl[17] = '{1'b0, 3'b010, 32'h10,  32'h0,        32'h123455EF, 1'b0};
        tbl[18] = '{1'b0, 3'b000, 32'h10,  32'h0,        32'hFFFFFFEF, 1'b0};
        tbl[19] = '{1'b0, 3'b101, 32'h10,  32'h0,        32'h000055EF, 1'b0};
        tbl[20] = '{1'b1, 3'b010, 32'hFC,  32'h11223344, 32'h0,        1'b0};
        tbl[21] = '{1'b0, 3'b010, 32'hFC,  32'h0,        32'h11223344, 1'b0};
        tbl[22] = '{1'b1, 3'b010, 32'h20,  32'h01020304, 32'h0,        1'b0};
        tbl[23] = '{1'b0, 3'b000, 32'h12,  32'h0,        32'h00000034, 1'b0};

        sel = 1'b0; reset = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_size = 3'b010; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset rsp_valid", 32'(rv0), 32'd0);
        chk("reset busy", 32'(busy0), 32'd0);
        chk("reset ready", 32'(ready0), 32'd0);
        chk("reset rdata", rdata0, 32'd0);
        chk("reset err", 32'(err0), 32'd0);
        @(negedge clk) reset = 1'b1;

        for (int i = 0; i < 24; i++) txn(2, tbl[i], $sformatf("vec%0d", i));

        sel = 1'b1;
        txn(0, '{1'b1, 3'b010, 32'h4, 32'hCAFEF00D, 32'h0, 1'b0}, "l0 sw");
        txn(0, '{1'b0, 3'b010, 32'h4, 32'h0, 32'hCAFEF00D, 1'b0}, "l0 lw");
        txn(0, '{1'b0, 3'b001, 32'h6, 32'h0, 32'hFFFFCAFE, 1'b0}, "l0 lh");

        acc = 0; rsp = 0; bad = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 3'b010; req_addr = 32'h4;
        for (int i = 0; i < 11; i++) begin
            if (i == 8) req_valid = 1'b0;
            #1;
            if (ready && req_valid) acc++;
            if (rv) rsp++;
            if (ready && busy) bad++;
            @(negedge clk);
        end
        chk("held accepts", 32'(acc), 32'd4);
        chk("held responses", 32'(rsp), 32'd4);
        chk("held ready while busy", 32'(bad), 32'd0);
        chk("held rdata", rdata, 32'hCAFEF00D);

        sel = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 3'b010;
        req_addr = 32'h20; req_wdata = 32'hAAAA5555;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("t6 busy before reset", 32'(busy), 32'd1);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 if (rv) seen++;
        end
        chk("t6 no rsp", 32'(seen), 32'd0);
        chk("t6 busy", 32'(busy), 32'd0);
        chk("t6 ready", 32'(ready), 32'd0);
        chk("t6 rdata", rdata, 32'd0);
        chk("t6 err", 32'(err), 32'd0);
        @(negedge clk) reset = 1'b1;
        v = '{1'b0, 3'b010, 32'h20, 32'h0, 32'h01020304, 1'b0};
        txn(2, v, "t6 lw");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
